param_table_streamer: RTL and testbench

//  Streams one entry of a constant parameter table as DATA_W-bit beats on a valid/ready source port.

---
 rtl/param_table_pkg.sv | 43 ++++
 rtl/param_table_streamer_if.sv | 33 +++
 rtl/param_beat_slicer.sv | 26 ++
 rtl/param_table_streamer.sv | 117 +++++++++++
 tb/tb_param_table_streamer.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/param_table_pkg.sv
// Parameter table contents and shared types for the table streamer.
// Entries are stored already truncated to their table width.
package param_table_pkg;

  localparam int NUM_ENTRIES = 11;
  localparam int MAX_W       = 600;
  localparam int IDX_W       = $clog2(NUM_ENTRIES);
  localparam int BEAT_W      = $clog2((MAX_W + 7) / 8 + 1);

  typedef struct packed {
    int unsigned      width;
    logic [MAX_W-1:0] value;
  } entry_t;

  localparam entry_t PARAM_TABLE [NUM_ENTRIES] = '{
    '{32'd1,   600'h1},
    '{32'd2,   600'h3},
    '{32'd600, 600'ha364c9849f8298c66d659},
    '{32'd8,   600'd100},
    '{32'd16,  600'hF618},
    '{32'd32,  600'd50},
    '{32'd64,  600'h11c98c031cb},
    '{32'd32,  600'd125000},
    '{32'd130, 600'h8c523ec7dc553a2b},
    '{32'd8,   600'd200},
    '{32'd64,  600'h2540be400}
  };

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STREAM,
    DONE
  } state_t;

  function automatic int unsigned ceil_div(
    input int unsigned a,
    input int unsigned b
  );
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/param_table_streamer_if.sv
// Valid/ready beat bus carrying table slices with framing and beat index.
// Master drives the beat, slave drives ready.
interface param_table_streamer_if #(
  parameter int DATA_W = 32,
  parameter int BEAT_W = param_table_pkg::BEAT_W
);

  logic              m_valid_o;
  logic              m_ready_i;
  logic [DATA_W-1:0] m_data_o;
  logic              m_first_o;
  logic              m_last_o;
  logic [BEAT_W-1:0] m_beat_o;

  modport master (
    output m_valid_o,
    output m_data_o,
    output m_first_o,
    output m_last_o,
    output m_beat_o,
    input  m_ready_i
  );

  modport slave (
    input  m_valid_o,
    input  m_data_o,
    input  m_first_o,
    input  m_last_o,
    input  m_beat_o,
    output m_ready_i
  );

endinterface

// File: rtl/param_beat_slicer.sv
// Picks beat `beat` out of a table value, zeroing bits at or past `width`.
// Purely combinational.
module param_beat_slicer
  import param_table_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [31:0]       width,
  input  logic [MAX_W-1:0]  value,
  input  logic [BEAT_W-1:0] beat,
  output logic [DATA_W-1:0] data
);

  logic [31:0]       base;
  logic [DATA_W-1:0] raw;

  always_comb begin
    base = 32'(beat) * 32'(DATA_W);
    raw  = DATA_W'(value >> base);
    data = '0;
    for (int i = 0; i < DATA_W; i++) begin
      data[i] = raw[i] & ((base + 32'(i)) < width);
    end
  end

endmodule

// File: rtl/param_table_streamer.sv
// Streams one parameter table entry as DATA_W-bit beats with backpressure.
// Beats sit in an output register so they hold while the sink stalls.
module param_table_streamer
  import param_table_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [IDX_W-1:0] sel_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  param_table_streamer_if.master m
);

  localparam logic [IDX_W-1:0] LAST_SEL = IDX_W'(NUM_ENTRIES - 1);

  state_t             state_q;
  state_t             state_d;
  logic [IDX_W-1:0]   sel_q;
  logic [MAX_W-1:0]   value_q;
  logic [31:0]        width_q;
  logic [BEAT_W-1:0]  nbeats_q;
  logic [BEAT_W-1:0]  cnt_q;
  logic               err_q;
  logic               sel_ok;
  logic               accept;
  logic               load_beat;
  logic               xfer;
  logic [DATA_W-1:0]  slice;

  assign sel_ok = sel_i <= LAST_SEL;
  assign xfer   = m.m_valid_o && m.m_ready_i;
  assign busy_o = (state_q == LOAD) || (state_q == STREAM);
  assign done_o = state_q == DONE;
  assign err_o  = err_q;

  param_beat_slicer #(
    .DATA_W(DATA_W)
  ) u_slicer (
    .width(width_q),
    .value(value_q),
    .beat (cnt_q),
    .data (slice)
  );

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    load_beat = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i && sel_ok) begin
          accept  = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: state_d = STREAM;
      STREAM: begin
        // refill the output register whenever it is empty or draining
        if (xfer && m.m_last_o) begin
          state_d = DONE;
        end else if (!m.m_valid_o || m.m_ready_i) begin
          load_beat = 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      value_q     <= '0;
      width_q     <= '0;
      nbeats_q    <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      m.m_valid_o <= 1'b0;
      m.m_data_o  <= '0;
      m.m_first_o <= 1'b0;
      m.m_last_o  <= 1'b0;
      m.m_beat_o  <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= (state_q == IDLE) && start_i && !sel_ok;
      if (accept) begin
        sel_q <= sel_i;
      end
      if (state_q == LOAD) begin
        value_q  <= PARAM_TABLE[sel_q].value;
        width_q  <= PARAM_TABLE[sel_q].width;
        nbeats_q <= BEAT_W'(ceil_div(PARAM_TABLE[sel_q].width, DATA_W));
        cnt_q    <= '0;
      end
      if (load_beat) begin
        m.m_valid_o <= 1'b1;
        m.m_data_o  <= slice;
        m.m_first_o <= cnt_q == '0;
        m.m_last_o  <= cnt_q == nbeats_q - 1'b1;
        m.m_beat_o  <= cnt_q;
        cnt_q       <= cnt_q + 1'b1;
      end else if (state_d == DONE) begin
        m.m_valid_o <= 1'b0;
        m.m_data_o  <= '0;
        m.m_first_o <= 1'b0;
        m.m_last_o  <= 1'b0;
        m.m_beat_o  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_param_table_streamer.sv
// Bench for param_table_streamer at DATA_W=32: table vectors, random
// backpressure against an arithmetic beat model, and corner sequences.
module tb_param_table_streamer;
  import param_table_pkg::*;

  localparam int DW = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [IDX_W-1:0] sel;
  logic             busy;
  logic             done;
  logic             err;

  int checks = 0;
  int errors = 0;

  logic [599:0] tv [11];
  int           tw [11];

  param_table_streamer_if #(.DATA_W(DW), .BEAT_W(BEAT_W)) bus ();

  param_table_streamer #(.DATA_W(DW)) dut (
    .clk    (clk),
    .rst    (rst),
    .start_i(start),
    .sel_i  (sel),
    .busy_o (busy),
    .done_o (done),
    .err_o  (err),
    .m      (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          s;
    int          nb;
    logic [31:0] b0;
    logic [31:0] bl;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_beat(input int s, input int k);
    logic [599:0] v;
    v = tv[s];
    if (tw[s] < 600) v = v & ((600'd1 << tw[s]) - 600'd1);
    v = v >> (k * DW);
    return v[31:0];
  endfunction

  // mode 0: always ready, 1: random ready, 2: alternating 1-0-1...
  task automatic run_stream(input int s, input int mode, input bit poke,
                            output int nb, output logic [31:0] d0,
                            output logic [31:0] dl);
    int k, exp_nb, cyc;
    bit fin, stalled, tog, poked;
    logic [40:0] held;
    k = 0; fin = 0; stalled = 0; tog = 1; poked = 0; cyc = 0;
    d0 = '0; dl = '0; held = '0;
    exp_nb = (tw[s] + DW - 1) / DW;
    bus.m_ready_i = 1'b0;
    start = 1'b1;
    sel = IDX_W'(s);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("valid_in_load", bus.m_valid_o, 0);
    @(negedge clk);
    chk("valid_lat_t1", bus.m_valid_o, 0);
    @(negedge clk);
    chk("valid_lat_t2", bus.m_valid_o, 1);
    while (!fin && cyc < 400) begin
      start = 1'b0;
      if (!bus.m_valid_o) begin
        chk("valid_dropped", bus.m_valid_o, 1);
        fin = 1;
      end else begin
        if (stalled)
          chk("hold_stable", {bus.m_data_o, bus.m_beat_o,
              bus.m_first_o, bus.m_last_o}, held);
        chk("beat_data", bus.m_data_o, model_beat(s, k));
        chk("beat_index", bus.m_beat_o, k);
        chk("beat_first", bus.m_first_o, k == 0);
        chk("beat_last", bus.m_last_o, k == exp_nb - 1);
        chk("busy_stream", busy, 1);
        if (k == 0) d0 = bus.m_data_o;
        dl = bus.m_data_o;
        if (poke && k == 1 && !poked) begin
          start = 1'b1;
          sel = IDX_W'(3);
          poked = 1;
        end
        case (mode)
          0: bus.m_ready_i = 1'b1;
          1: bus.m_ready_i = 1'($urandom_range(0, 1));
          default: begin
            bus.m_ready_i = tog;
            tog = !tog;
          end
        endcase
        held = {bus.m_data_o, bus.m_beat_o, bus.m_first_o, bus.m_last_o};
        stalled = !bus.m_ready_i;
        if (bus.m_ready_i) begin
          if (bus.m_last_o) fin = 1;
          k++;
        end
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    bus.m_ready_i = 1'b0;
    chk("stream_finished", fin, 1);
    chk("done_pulse", done, 1);
    chk("busy_in_done", busy, 0);
    chk("valid_in_done", bus.m_valid_o, 0);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("idle_not_busy", busy, 0);
    chk("idle_no_err", err, 0);
    nb = k;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got running want finished");
    $fatal(1);
  end

  initial begin
    int nb;
    logic [31:0] d0, dl;
    bit seen;

    tw = '{1, 2, 600, 8, 16, 32, 64, 32, 130, 8, 64};
    tv[0] = 600'h1;  tv[1] = 600'h3;
    tv[2] = 600'ha364c9849f8298c66d659;
    tv[3] = 600'd100; tv[4] = 600'd63000;
    tv[5] = 600'd50; tv[6] = 600'h11c98c031cb;
    tv[7] = 600'd125000; tv[8] = 600'h8c523ec7dc553a2b;
    tv[9] = 600'd200; tv[10] = 600'h2540be400;

    vecs[0]  = '{0, 1, 32'h1, 32'h1};
    vecs[1]  = '{1, 1, 32'h3, 32'h3};
    vecs[2]  = '{2, 19, 32'h8c66d659, 32'h0};
    vecs[3]  = '{3, 1, 32'h64, 32'h64};
    vecs[4]  = '{4, 1, 32'hF618, 32'hF618};
    vecs[5]  = '{5, 1, 32'h32, 32'h32};
    vecs[6]  = '{6, 2, 32'h98c031cb, 32'h11c};
    vecs[7]  = '{7, 1, 32'h0001E848, 32'h0001E848};
    vecs[8]  = '{8, 5, 32'hdc553a2b, 32'h0};
    vecs[9]  = '{9, 1, 32'hC8, 32'hC8};
    vecs[10] = '{10, 2, 32'h540be400, 32'h2};

    rst = 1'b1; start = 1'b0; sel = '0; bus.m_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {busy, done, err, bus.m_valid_o, bus.m_data_o,
        bus.m_first_o, bus.m_last_o, bus.m_beat_o}, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      run_stream(vecs[i].s, 0, 0, nb, d0, dl);
      chk($sformatf("vec%0d_nbeats", i), nb, vecs[i].nb);
      chk($sformatf("vec%0d_beat0", i), d0, vecs[i].b0);
      chk($sformatf("vec%0d_lastbeat", i), dl, vecs[i].bl);
    end

    run_stream(6, 2, 0, nb, d0, dl);
    chk("stall_sel6_last", dl, 32'h0000011c);

    foreach (vecs[i]) begin
      logic [IDX_W-1:0] bad;
      if (i > 1) break;
      bad = (i == 0) ? IDX_W'(15) : IDX_W'(11);
      start = 1'b1; sel = bad;
      @(negedge clk);
      start = 1'b0;
      chk("err_pulse", err, 1);
      chk("err_not_busy", busy, 0);
      @(negedge clk);
      chk("err_one_cycle", err, 0);
      chk("err_no_valid", {busy, bus.m_valid_o}, 0);
    end

    run_stream(8, 0, 1, nb, d0, dl);
    chk("ignored_start_nbeats", nb, 5);
    @(negedge clk);
    chk("ignored_start_not_queued", {busy, bus.m_valid_o}, 0);

    start = 1'b1; sel = IDX_W'(2); bus.m_ready_i = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    for (int c = 0; c < 30 && !seen; c++) begin
      if (bus.m_valid_o && bus.m_beat_o == 7'd5) seen = 1;
      else @(negedge clk);
    end
    chk("reached_beat5", seen, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midstream_reset", {busy, done, err, bus.m_valid_o, bus.m_data_o,
        bus.m_first_o, bus.m_last_o, bus.m_beat_o}, 0);
    rst = 1'b0;
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (done || bus.m_valid_o) seen = 1;
    end
    chk("abandoned_no_done", seen, 0);
    run_stream(4, 0, 0, nb, d0, dl);
    chk("after_reset_nbeats", nb, 1);
    chk("after_reset_data", d0, 32'h0000F618);

    for (int r = 0; r < 20; r++) begin
      int s;
      s = $urandom_range(0, 10);
      run_stream(s, 1, 0, nb, d0, dl);
      chk("rand_nbeats", nb, (tw[s] + DW - 1) / DW);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
